// File: rtl/ifu_prefetch_pkg.sv
// Shared definitions for the prefetching IFU: next-PC select codes, code-segment base, queue entry.
package ifu_prefetch_pkg;

  localparam logic [1:0] NPC_SEL_PC_ADD_4 = 2'b00;
  localparam logic [1:0] NPC_SEL_REG_JMP  = 2'b01;
  localparam logic [1:0] NPC_SEL_J_JMP    = 2'b10;
  localparam logic [1:0] NPC_SEL_BEQ_JMP  = 2'b11;

  localparam logic [31:0] CODE_SEG_PC = 32'h0000_3000;
  localparam int unsigned ENTRY_WIDTH = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Resolved redirect target; imm16 is the low half of imm26.
  function automatic logic [31:0] npc_target(input logic [1:0]  sel,
                                             input logic [31:0] pc,
                                             input logic [25:0] imm26,
                                             input logic [31:0] reg_target);
    logic [31:0] pc4;
    logic [31:0] target;
    pc4 = pc + 32'd4;
    case (sel)
      NPC_SEL_REG_JMP: target = reg_target;
      NPC_SEL_J_JMP:   target = {pc4[31:28], imm26, 2'b00};
      NPC_SEL_BEQ_JMP: target = pc4 + {{14{imm26[15]}}, imm26[15:0], 2'b00};
      default:         target = pc4;
    endcase
    return target;
  endfunction

endpackage

// File: rtl/ifu_fetch_queue.sv
// Generic circular FIFO with push/pop/flush; DEPTH must be a power of two so pointers wrap freely.
module ifu_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rptr];
  assign empty = (count == '0);

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: PC register, internal instruction memory im, prefetch queue toward decode.
// Optional misaligned-target fault detection is enabled by defining IFU_ALIGN_CHECK_EN.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = CODE_SEG_PC,
  parameter int unsigned IM_ADDR_WIDTH = 10,
  parameter int unsigned DEPTH         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic [1:0]  redirect_sel,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] redirect_instr,
  input  logic [31:0] reg_target,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_pc,
  output logic        fault
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0] im [1 << IM_ADDR_WIDTH];

  logic [31:0]              pc_off;
  logic [IM_ADDR_WIDTH-1:0] im_idx;
  logic [31:0]              target_raw;
  logic [31:0]              target;
  logic                     redirect;
  logic                     pop_req;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     q_empty;
  logic [CW-1:0]            q_count;
  entry_t                   q_din;
  entry_t                   q_dout;

  // Index relative to the code-segment base; high bits drop so out-of-range PCs wrap.
  assign pc_off     = fetch_pc - RESET_PC;
  assign im_idx     = pc_off[IM_ADDR_WIDTH+1:2];
  assign target_raw = npc_target(redirect_sel, redirect_pc, redirect_instr[25:0], reg_target);
  assign redirect   = (redirect_sel != NPC_SEL_PC_ADD_4);

`ifdef IFU_ALIGN_CHECK_EN
  logic fault_q;
  assign target = target_raw;
  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (redirect && (target_raw[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end
  assign fault = fault_q;
`else
  assign target = {target_raw[31:2], 2'b00};
  assign fault  = 1'b0;
`endif

  assign full    = (q_count == CW'(DEPTH));
  assign pop_req = inst_valid && inst_ready;
  assign pop     = pop_req && !redirect;
  assign push    = fetch_en && !redirect && !fault && (!full || pop_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= target;
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  assign q_din = '{pc: fetch_pc, instr: im[im_idx]};

  ifu_fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_WIDTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (q_din),
    .dout  (q_dout),
    .empty (q_empty),
    .count (q_count)
  );

  assign inst_valid = !q_empty;
  assign inst       = q_dout.instr;
  assign inst_pc    = q_dout.pc;

  logic unused_bits;
  assign unused_bits = ^{pc_off[31:IM_ADDR_WIDTH+2], pc_off[1:0], redirect_instr[31:26],
                         target_raw[1:0]};

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed self-checking bench for ifu_prefetch; expectations hand-derived from the PC/queue rules.
module tb_ifu_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [1:0]  redirect_sel;
  logic [31:0] redirect_pc;
  logic [31:0] redirect_instr;
  logic [31:0] reg_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] fetch_pc;
  logic        fault;

  int tests = 0;
  int fails = 0;

  ifu_prefetch dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_sel   (redirect_sel),
    .redirect_pc    (redirect_pc),
    .redirect_instr (redirect_instr),
    .reg_target     (reg_target),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_pc       (fetch_pc),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input int idx);
    return 32'hC0DE_0000 | (idx & 32'h3FF);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [1:0] sel, input logic [31:0] rpc,
                          input logic [31:0] rinstr, input logic [31:0] rtgt);
    redirect_sel   = sel;
    redirect_pc    = rpc;
    redirect_instr = rinstr;
    reg_target     = rtgt;
    step();
    redirect_sel = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) dut.im[i] = mem_word(i);
    reset          = 1'b1;
    fetch_en       = 1'b1;
    inst_ready     = 1'b0;
    redirect_sel   = 2'b00;
    redirect_pc    = '0;
    redirect_instr = '0;
    reg_target     = '0;
    step();
    step();
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'h3000);
    check("rst_fault", {31'b0, fault}, 32'd0);

    // Fill: first entry visible one cycle after reset drops, then stall at four.
    reset = 1'b0;
    step();
    check("first_valid", {31'b0, inst_valid}, 32'd1);
    check("first_pc", inst_pc, 32'h3000);
    for (int i = 0; i < 5; i++) step();
    check("fill_valid", {31'b0, inst_valid}, 32'd1);
    check("fill_head_pc", inst_pc, 32'h3000);
    check("fill_head_inst", inst, mem_word(0));
    check("fill_fetch_pc", fetch_pc, 32'h3010);
    check("fill_count", 32'(dut.u_queue.count), 32'd4);

    // Streaming on a full queue: one entry per cycle, pointers wrap.
    inst_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("stream_pc%0d", k), inst_pc, 32'h3000 + 32'(4 * k));
      check($sformatf("stream_inst%0d", k), inst, mem_word(k));
    end
    check("stream_fetch_pc", fetch_pc, 32'h3028);

    // fetch_en low: PC frozen while decode drains.
    fetch_en = 1'b0;
    step();
    step();
    check("hold_fetch_pc", fetch_pc, 32'h3028);
    check("hold_count", 32'(dut.u_queue.count), 32'd2);
    check("hold_head_pc", inst_pc, 32'h3020);
    fetch_en   = 1'b1;
    inst_ready = 1'b0;
    step();
    step();
    step();
    check("refill_count", 32'(dut.u_queue.count), 32'd4);

    // REG redirect with a full queue.
    redirect(2'b01, 32'h0, 32'h0, 32'h3100);
    check("reg_flush_valid", {31'b0, inst_valid}, 32'd0);
    check("reg_fetch_pc", fetch_pc, 32'h3100);
    step();
    check("reg_valid", {31'b0, inst_valid}, 32'd1);
    check("reg_pc", inst_pc, 32'h3100);
    check("reg_inst", inst, mem_word(32'h40));

    // J keeps only (pc+4)[31:28], so the target is 0x114; its memory index is still 45h.
    redirect(2'b10, 32'h3100, 32'h0800_0045, 32'h0);
    check("j_flush_valid", {31'b0, inst_valid}, 32'd0);
    step();
    check("j_pc", inst_pc, 32'h0000_0114);
    check("j_inst", inst, mem_word(32'h45));

    // BEQ backward (imm16 = -5) and zero offset.
    redirect(2'b11, 32'h3118, 32'h1000_FFFB, 32'h0);
    step();
    check("beq_back_pc", inst_pc, 32'h3108);
    check("beq_back_inst", inst, mem_word(32'h42));
    redirect(2'b11, 32'h3118, 32'h1000_0000, 32'h0);
    step();
    check("beq_zero_pc", inst_pc, 32'h311C);
    check("beq_zero_inst", inst, mem_word(32'h47));

    // Misaligned REG target.
    redirect(2'b01, 32'h0, 32'h0, 32'h3102);
    check("mis_flush_valid", {31'b0, inst_valid}, 32'd0);
    step();
`ifdef IFU_ALIGN_CHECK_EN
    step();
    check("mis_fault", {31'b0, fault}, 32'd1);
    check("mis_valid", {31'b0, inst_valid}, 32'd0);
    check("mis_fetch_pc", fetch_pc, 32'h3102);
`else
    check("mis_fault", {31'b0, fault}, 32'd0);
    check("mis_valid", {31'b0, inst_valid}, 32'd1);
    check("mis_pc", inst_pc, 32'h3100);
`endif

    // Reset wins over a pending redirect in the same cycle.
    reset          = 1'b1;
    redirect_sel   = 2'b01;
    reg_target     = 32'h3200;
    step();
    redirect_sel = 2'b00;
    check("midrst_fetch_pc", fetch_pc, 32'h3000);
    check("midrst_valid", {31'b0, inst_valid}, 32'd0);
    check("midrst_fault", {31'b0, fault}, 32'd0);
    reset = 1'b0;
    step();
    check("midrst_pc", inst_pc, 32'h3000);
    check("midrst_inst", inst, mem_word(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
